mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/riscv_mem_pkg.sv | 24 ++
 rtl/arb_timer.sv | 41 ++++
 rtl/mem_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg: shared state, owner encoding and default widths for the memory arbiter.
// Rev 1.0
`default_nettype none

package riscv_mem_pkg;

   localparam int DEF_ADDR_W = 32;
   localparam int DEF_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      GRANT_IF = 2'd1,
      GRANT_D  = 2'd2,
      RESP     = 2'd3
   } arb_state_e;

   typedef enum logic {
      OWNER_IF = 1'b0,
      OWNER_D  = 1'b1
   } owner_e;

endpackage

`default_nettype wire

// File: rtl/arb_timer.sv
// arb_timer: memory wait counter, expired on the wait cycle that completes TIMEOUT cycles.
// Rev 1.0
`default_nettype none

module arb_timer #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // cnt_q holds the wait cycles already spent, so this cycle is the TIMEOUT-th one.
   assign expired = enable && (cnt_q == CNT_W'(TIMEOUT - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable && !expired) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// mem_arbiter: fetch/data arbiter for one shared memory port with starvation guard and timeout.
// Rev 1.0
`default_nettype none

module mem_arbiter
   import riscv_mem_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int STREAK_MAX = 4,
   parameter int TIMEOUT    = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ack,
   output logic              if_err,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ack,
   output logic              d_err,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   localparam int STREAK_W = $clog2(STREAK_MAX + 1);

   arb_state_e          state_q, state_d;
   owner_e              owner_q, owner_d;
   logic [STREAK_W-1:0] streak_q, streak_d;
   logic                mem_req_q, mem_req_d, mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic                if_ack_q, if_ack_d, if_err_q, if_err_d;
   logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
   logic                d_ack_q, d_ack_d, d_err_q, d_err_d;
   logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
   logic                busy_q, busy_d;

   logic                in_grant, tmr_clear, tmr_enable, tmr_expired;
   logic                pick_d, cap_err;
   logic [DATA_W-1:0]   cap_data;

   assign in_grant   = (state_q == GRANT_IF) || (state_q == GRANT_D);
   assign tmr_clear  = !in_grant;
   assign tmr_enable = in_grant && !mem_ready;

   arb_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (tmr_clear),
      .enable  (tmr_enable),
      .expired (tmr_expired)
   );

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      streak_d    = streak_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if_ack_d    = 1'b0;
      if_err_d    = if_err_q;
      if_rdata_d  = if_rdata_q;
      d_ack_d     = 1'b0;
      d_err_d     = d_err_q;
      d_rdata_d   = d_rdata_q;
      // Data normally wins; a full streak hands the port to a waiting fetch.
      pick_d      = d_req && (!if_req || (streak_q != STREAK_W'(STREAK_MAX)));
      cap_err     = !mem_ready;
      cap_data    = (mem_ready && !mem_we_q) ? mem_rdata : '0;

      case (state_q)
         IDLE: begin
            if (if_req || d_req) begin
               mem_req_d = 1'b1;
               if (pick_d) begin
                  state_d     = GRANT_D;
                  owner_d     = OWNER_D;
                  mem_we_d    = d_we;
                  mem_addr_d  = d_addr;
                  mem_wdata_d = d_wdata;
                  if (if_req && (streak_q != STREAK_W'(STREAK_MAX))) begin
                     streak_d = streak_q + 1'b1;
                  end
               end else begin
                  state_d     = GRANT_IF;
                  owner_d     = OWNER_IF;
                  mem_we_d    = 1'b0;
                  mem_addr_d  = if_addr;
                  mem_wdata_d = '0;
                  streak_d    = '0;
               end
            end
         end
         GRANT_IF, GRANT_D: begin
            if (mem_ready || tmr_expired) begin
               state_d   = RESP;
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
               if (owner_q == OWNER_IF) begin
                  if_ack_d   = 1'b1;
                  if_err_d   = cap_err;
                  if_rdata_d = cap_data;
               end else begin
                  d_ack_d   = 1'b1;
                  d_err_d   = cap_err;
                  d_rdata_d = cap_data;
               end
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         owner_q     <= OWNER_IF;
         streak_q    <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_ack_q    <= 1'b0;
         if_err_q    <= 1'b0;
         if_rdata_q  <= '0;
         d_ack_q     <= 1'b0;
         d_err_q     <= 1'b0;
         d_rdata_q   <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         streak_q    <= streak_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if_ack_q    <= if_ack_d;
         if_err_q    <= if_err_d;
         if_rdata_q  <= if_rdata_d;
         d_ack_q     <= d_ack_d;
         d_err_q     <= d_err_d;
         d_rdata_q   <= d_rdata_d;
         busy_q      <= busy_d;
      end
   end

   assign if_ack    = if_ack_q;
   assign if_err    = if_err_q;
   assign if_rdata  = if_rdata_q;
   assign d_ack     = d_ack_q;
   assign d_err     = d_err_q;
   assign d_rdata   = d_rdata_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: random and directed stimulus against a transaction-level arbiter model.
// Rev 1.0
`default_nettype none

module tb_mem_arbiter;

   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int SMAX = 4;
   localparam int TMO  = 255;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          if_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ready = 1'b0;
   logic [AW-1:0] if_addr = '0, d_addr = '0;
   logic [DW-1:0] d_wdata = '0, mem_rdata = '0;
   logic          if_ack, if_err, d_ack, d_err, mem_req, mem_we, busy;
   logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
   logic [AW-1:0] mem_addr;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STREAK_MAX(SMAX), .TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_err(if_err), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata), .busy(busy)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction-level model: which requester holds the port, how long it has waited,
   // whether a reply cycle is due, and how many data wins a waiting fetch has seen.
   int            m_owner;   // -1 none, 0 fetch, 1 data
   int            m_waited;
   bit            m_reply;
   int            m_streak;
   logic          e_mem_req, e_mem_we, e_if_ack, e_if_err, e_d_ack, e_d_err, e_busy;
   logic [AW-1:0] e_mem_addr;
   logic [DW-1:0] e_mem_wdata, e_if_rdata, e_d_rdata;

   task automatic model_reset();
      m_owner = -1; m_waited = 0; m_reply = 0; m_streak = 0;
      e_mem_req = 0; e_mem_we = 0; e_mem_addr = '0; e_mem_wdata = '0;
      e_if_ack = 0; e_if_err = 0; e_if_rdata = '0;
      e_d_ack = 0; e_d_err = 0; e_d_rdata = '0; e_busy = 0;
   endtask

   task automatic model_step();
      logic [DW-1:0] v;
      bit            er, take_d;
      if (!reset) begin
         model_reset();
         return;
      end
      e_if_ack = 0;
      e_d_ack  = 0;
      if (m_reply) begin
         m_reply = 0;
      end else if (m_owner >= 0) begin
         if (mem_ready || (m_waited + 1 >= TMO)) begin
            er = !mem_ready;
            v  = (mem_ready && !e_mem_we) ? mem_rdata : '0;
            if (m_owner == 0) begin
               e_if_ack = 1; e_if_err = er; e_if_rdata = v;
            end else begin
               e_d_ack = 1; e_d_err = er; e_d_rdata = v;
            end
            m_owner = -1; m_reply = 1; e_mem_req = 0; e_mem_we = 0;
         end else begin
            m_waited++;
         end
      end else if (if_req || d_req) begin
         take_d    = d_req && !(if_req && m_streak >= SMAX);
         m_waited  = 0;
         e_mem_req = 1;
         if (take_d) begin
            m_owner = 1; e_mem_we = d_we; e_mem_addr = d_addr; e_mem_wdata = d_wdata;
            if (if_req && m_streak < SMAX) m_streak++;
         end else begin
            m_owner = 0; e_mem_we = 0; e_mem_addr = if_addr; e_mem_wdata = '0;
            m_streak = 0;
         end
      end
      e_busy = m_reply || (m_owner >= 0);
   endtask

   always @(negedge clk) begin
      chk("busy", busy, e_busy);
      chk("mem_req", mem_req, e_mem_req);
      chk("if_ack", if_ack, e_if_ack);
      chk("if_err", if_err, e_if_err);
      chk("if_rdata", if_rdata, e_if_rdata);
      chk("d_ack", d_ack, e_d_ack);
      chk("d_err", d_err, e_d_err);
      chk("d_rdata", d_rdata, e_d_rdata);
      if (e_mem_req) begin
         chk("mem_we", mem_we, e_mem_we);
         chk("mem_addr", mem_addr, e_mem_addr);
         chk("mem_wdata", mem_wdata, e_mem_wdata);
      end
   end

   // Memory responder: ready after lat cycles of mem_req (-1 = never).
   int            lat = 1;
   int            rcnt = 0;
   bit            spur = 0, rand_lat = 0, fix_en = 0;
   logic [DW-1:0] fix_data = '0;

   task automatic step();
      @(posedge clk);
      model_step();
      @(negedge clk);
      #1;
      if (mem_req) begin
         mem_ready = (lat >= 0) && (rcnt == lat);
         rcnt++;
      end else begin
         rcnt = 0;
         mem_ready = spur ? ($urandom_range(3) == 0) : 1'b0;
         if (rand_lat) lat = ($urandom_range(49) == 0) ? -1 : int'($urandom_range(3));
      end
      mem_rdata = fix_en ? fix_data : DW'($urandom);
   endtask

   task automatic do_reset();
      reset = 0;
      model_reset();
      if_req = 0; d_req = 0; d_we = 0;
      step();
      step();
      reset = 1;
   endtask

   task automatic wait_ack(input bit data_side, output int n, output int req_cycles);
      bit got = 0;
      n = 0;
      req_cycles = 0;
      for (int i = 0; i < 400 && !got; i++) begin
         step();
         n++;
         if (mem_req) req_cycles++;
         got = data_side ? d_ack : if_ack;
      end
      chk(data_side ? "wait_d_ack" : "wait_if_ack", got, 1'b1);
   endtask

   initial begin
      int           n, rc, acks;
      logic [5:0]   seq;
      int           grants;
      logic         prev_req;

      model_reset();
      step();
      chk("reset_busy", busy, 1'b0);
      chk("reset_mem_req", mem_req, 1'b0);
      chk("reset_acks", {if_ack, d_ack}, 2'b00);
      reset = 1;

      // Single fetch, memory answers on the third mem_req cycle.
      lat = 2; fix_en = 1; fix_data = 32'h0000_0013;
      if_addr = 32'h100; if_req = 1;
      wait_ack(0, n, rc);
      chk("fetch_latency", n, 4);
      chk("fetch_rdata", if_rdata, 32'h13);
      chk("fetch_err", if_err, 1'b0);
      if_req = 0;
      step();
      chk("fetch_ack_pulse", if_ack, 1'b0);
      chk("fetch_rdata_hold", if_rdata, 32'h13);

      // Simultaneous store and fetch: store first, then the fetch.
      do_reset();
      if_addr = 32'h300; if_req = 1;
      d_we = 1; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF; d_req = 1;
      step();
      chk("store_first_we", mem_we, 1'b1);
      chk("store_first_addr", mem_addr, 32'h2000);
      chk("store_first_wdata", mem_wdata, 32'hDEAD_BEEF);
      wait_ack(1, n, rc);
      chk("store_rdata", d_rdata, 32'h0);
      chk("store_if_ack", if_ack, 1'b0);
      d_req = 0;
      step();
      step();
      chk("then_fetch_req", mem_req, 1'b1);
      chk("then_fetch_we", mem_we, 1'b0);
      chk("then_fetch_addr", mem_addr, 32'h300);
      wait_ack(0, n, rc);
      if_req = 0;

      // Continuous stores with a waiting fetch: four stores, one fetch, then stores again.
      do_reset();
      lat = 0; fix_en = 0;
      if_req = 1; if_addr = 32'h400;
      d_req = 1; d_we = 1; d_addr = $urandom; d_wdata = $urandom;
      seq = '0; grants = 0; prev_req = 0;
      for (int i = 0; i < 100 && grants < 6; i++) begin
         step();
         if (mem_req && !prev_req) begin
            seq = {seq[4:0], mem_we};
            grants++;
         end
         prev_req = mem_req;
         if (d_ack) begin d_addr = $urandom; d_wdata = $urandom; end
         if (if_ack) if_addr = $urandom;
      end
      chk("streak_grant_order", seq, 6'b111101);
      if_req = 0; d_req = 0;
      step(); step(); step();

      // No memory answer: timeout after 255 wait cycles.
      do_reset();
      lat = -1;
      if_addr = 32'h500; if_req = 1;
      wait_ack(0, n, rc);
      chk("timeout_req_cycles", rc, 255);
      chk("timeout_err", if_err, 1'b1);
      chk("timeout_rdata", if_rdata, 32'h0);
      if_req = 0;

      // Answer on the very cycle the timer would expire.
      lat = 254; fix_en = 1; fix_data = 32'hCAFE_F00D;
      d_we = 0; d_addr = 32'h600; d_req = 1;
      wait_ack(1, n, rc);
      chk("edge_req_cycles", rc, 255);
      chk("edge_err", d_err, 1'b0);
      chk("edge_rdata", d_rdata, 32'hCAFE_F00D);
      d_req = 0;

      // Reset in the middle of a data access.
      step();
      lat = -1;
      d_req = 1; d_addr = 32'h700;
      step(); step(); step();
      chk("pre_reset_req", mem_req, 1'b1);
      #2;
      reset = 0;
      model_reset();
      #1;
      chk("async_mem_req", mem_req, 1'b0);
      chk("async_busy", busy, 1'b0);
      chk("async_acks", {if_ack, d_ack}, 2'b00);
      d_req = 0;
      step(); step();
      reset = 1;
      acks = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         acks += int'(if_ack) + int'(d_ack);
      end
      chk("no_ack_after_reset", acks, 0);
      lat = 1; fix_en = 0;
      d_req = 1;
      wait_ack(1, n, rc);
      chk("post_reset_err", d_err, 1'b0);
      d_req = 0;

      // Random traffic with spurious mem_ready outside grants.
      do_reset();
      spur = 1; rand_lat = 1;
      for (int i = 0; i < 5000; i++) begin
         step();
         if (if_req) begin
            if (if_ack) begin
               if_req = 1'($urandom_range(1)); if_addr = $urandom;
            end else if (m_owner != 0 && $urandom_range(31) == 0) begin
               if_req = 0;
            end
         end else if ($urandom_range(2) == 0) begin
            if_req = 1; if_addr = $urandom;
         end
         if (d_req) begin
            if (d_ack) begin
               d_req = 1'($urandom_range(1)); d_we = 1'($urandom_range(1));
               d_addr = $urandom; d_wdata = $urandom;
            end else if (m_owner != 1 && $urandom_range(31) == 0) begin
               d_req = 0;
            end
         end else if ($urandom_range(2) == 0) begin
            d_req = 1; d_we = 1'($urandom_range(1)); d_addr = $urandom; d_wdata = $urandom;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
